alu: RTL and testbench

//  Registered 8-op integer ALU. Two unsigned WIDTH-bit operands and a 3-bit opcode.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_if.sv | 29 ++
 rtl/alu_comb.sv | 41 ++++
 rtl/alu.sv | 42 ++++
 tb/tb_alu.sv | 137 +++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the registered integer ALU.
// Opcode encodings and default operand/result widths.
package alu_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int MUL_WIDTH_DEF = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode/result bundle for the ALU.
// The master drives operands and opcode; the slave returns the result.
interface alu_if
    import alu_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int MUL_WIDTH = MUL_WIDTH_DEF
);

    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2:0]           opsel;
    logic [MUL_WIDTH-1:0] result;

    modport master (
        output a,
        output b,
        output opsel,
        input  result
    );

    modport slave (
        input  a,
        input  b,
        input  opsel,
        output result
    );

endinterface

// File: rtl/alu_comb.sv
// Combinational operation decode and compute for the ALU.
// Operands are zero-extended to the result width before every op.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int MUL_WIDTH = MUL_WIDTH_DEF
) (
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic [2:0]           opsel_i,
    output logic [MUL_WIDTH-1:0] next_result_o
);

    localparam int SHW = $clog2(MUL_WIDTH);

    logic [MUL_WIDTH-1:0] a_ext;
    logic [MUL_WIDTH-1:0] b_ext;
    logic [SHW-1:0]       shamt;

    assign a_ext = {{(MUL_WIDTH-WIDTH){1'b0}}, a_i};
    assign b_ext = {{(MUL_WIDTH-WIDTH){1'b0}}, b_i};
    // Only the low bits of b steer the shifters; upper bits are ignored.
    assign shamt = b_i[SHW-1:0];

    // Select the operation result for the current opcode.
    always_comb begin
        next_result_o = '0;
        unique case (opsel_i)
            OP_ADD: next_result_o = a_ext + b_ext;
            OP_SUB: next_result_o = a_ext - b_ext;
            OP_MUL: next_result_o = a_ext * b_ext;
            OP_AND: next_result_o = a_ext & b_ext;
            OP_OR:  next_result_o = a_ext | b_ext;
            OP_XOR: next_result_o = a_ext ^ b_ext;
            OP_SHL: next_result_o = a_ext << shamt;
            OP_SHR: next_result_o = a_ext >> shamt;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered 8-op integer ALU with one cycle of latency.
// A new operation is sampled on every rising clock edge.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int MUL_WIDTH = MUL_WIDTH_DEF
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);

    if (MUL_WIDTH != 2 * WIDTH) begin : g_bad_width
        $error("alu: MUL_WIDTH must equal 2*WIDTH");
    end

    logic [MUL_WIDTH-1:0] result_d;
    logic [MUL_WIDTH-1:0] result_q;

    alu_comb #(
        .WIDTH     (WIDTH),
        .MUL_WIDTH (MUL_WIDTH)
    ) u_comb (
        .a_i           (bus.a),
        .b_i           (bus.b),
        .opsel_i       (bus.opsel),
        .next_result_o (result_d)
    );

    // Result register; reset drops whatever op was sampled that edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign bus.result = result_q;

endmodule

// File: tb/tb_alu.sv
// Directed and random checks for the registered ALU.
// Expected values come from hand-computed constants and a small model.
module tb_alu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int tests = 0;
    int fails = 0;

    alu_if #(.WIDTH(8), .MUL_WIDTH(16)) bus ();

    alu #(.WIDTH(8), .MUL_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned op);
        int unsigned r;
        int unsigned s;
        s = b % 16;
        case (op)
            0: r = a + b;
            1: r = (a + 65536 - b) % 65536;
            2: r = a * b;
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = (a << s) % 65536;
            default: r = a >> s;
        endcase
        return r[15:0];
    endfunction

    task automatic check(input string tag, input logic [15:0] exp);
        tests++;
        assert (bus.result === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, bus.result, exp);
        end
    endtask

    task automatic step(input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic rst,
                        input logic [15:0] exp, input string tag);
        bus.a = a;
        bus.b = b;
        bus.opsel = op;
        rst_n = rst;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [2:0] rop;
        logic       rr;
        logic [7:0] cov;
        cov = '0;
        bus.a = 8'hFF;
        bus.b = 8'hFF;
        bus.opsel = 3'b010;

        // Reset holds result at zero while a MUL is presented
        step(8'hFF, 8'hFF, 3'b010, 1'b0, 16'h0000, "rst_edge1");
        step(8'hFF, 8'hFF, 3'b010, 1'b0, 16'h0000, "rst_edge2");
        step(8'hFF, 8'hFF, 3'b010, 1'b1, 16'hFE01, "rst_release");

        // Arithmetic
        step(8'd200, 8'd100, 3'b000, 1'b1, 16'd300,  "add_200_100");
        step(8'd255, 8'd255, 3'b000, 1'b1, 16'd510,  "add_carry");
        step(8'd3,   8'd5,   3'b001, 1'b1, 16'hFFFE, "sub_3_5");
        step(8'd5,   8'd3,   3'b001, 1'b1, 16'd2,    "sub_5_3");
        step(8'd255, 8'd255, 3'b010, 1'b1, 16'd65025, "mul_max");
        step(8'd0,   8'd173, 3'b010, 1'b1, 16'd0,    "mul_zero");

        // Logic
        step(8'hF0, 8'h3C, 3'b011, 1'b1, 16'h0030, "and");
        step(8'hF0, 8'h3C, 3'b100, 1'b1, 16'h00FC, "or");
        step(8'hF0, 8'h3C, 3'b101, 1'b1, 16'h00CC, "xor");
        step(8'hFF, 8'hFF, 3'b011, 1'b1, 16'h00FF, "and_ff");

        // Shifts
        step(8'h81, 8'd8,   3'b110, 1'b1, 16'h8100, "shl_8");
        step(8'h81, 8'd15,  3'b110, 1'b1, 16'h8000, "shl_15");
        step(8'h81, 8'hF1,  3'b110, 1'b1, 16'h0102, "shl_hi_ign");
        step(8'h81, 8'd7,   3'b111, 1'b1, 16'h0001, "shr_7");
        step(8'h81, 8'd8,   3'b111, 1'b1, 16'h0000, "shr_8");
        step(8'h81, 8'hF3,  3'b111, 1'b1, 16'h0010, "shr_hi_ign");

        // Mid-stream reset discards the pending op, then resumes
        step(8'd10, 8'd20, 3'b000, 1'b0, 16'h0000, "mid_rst");
        step(8'd7,  8'd6,  3'b010, 1'b1, 16'd42,   "post_rst");

        // Back-to-back streaming over all opcodes
        step(8'h5A, 8'h33, 3'b000, 1'b1, 16'h008D, "stream_add");
        step(8'h5A, 8'h33, 3'b001, 1'b1, 16'h0027, "stream_sub");
        step(8'h5A, 8'h33, 3'b010, 1'b1, 16'h11EE, "stream_mul");
        step(8'h5A, 8'h33, 3'b011, 1'b1, 16'h0012, "stream_and");
        step(8'h5A, 8'h33, 3'b100, 1'b1, 16'h007B, "stream_or");
        step(8'h5A, 8'h33, 3'b101, 1'b1, 16'h0069, "stream_xor");
        step(8'h5A, 8'h33, 3'b110, 1'b1, 16'h02D0, "stream_shl");
        step(8'h5A, 8'h33, 3'b111, 1'b1, 16'h000B, "stream_shr");

        // Random with occasional reset pulses and corner operands
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 3))
                0: ra = 8'h00;
                1: ra = 8'hFF;
                default: ra = 8'($urandom_range(0, 255));
            endcase
            case ($urandom_range(0, 3))
                0: rb = 8'h00;
                1: rb = 8'hFF;
                default: rb = 8'($urandom_range(0, 255));
            endcase
            rop = 3'($urandom_range(0, 7));
            rr = ($urandom_range(0, 19) != 0);
            if (rr) cov[rop] = 1'b1;
            step(ra, rb, rop, rr,
                 rr ? model(ra, rb, rop) : 16'h0000, "random");
        end
        if (cov != 8'hFF) $display("[TB] note: opcode coverage %b", cov);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
